// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Producer side of the single register-file write port. Pipeline
//   writebacks have fixed priority and no back-pressure. Long-latency
//   (mult/div) results are buffered in a strict-order FIFO. When the FIFO
//   fills, or its head has waited STARVE_LIMIT cycles, the block stalls the
//   pipeline and drains the FIFO.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : Byp_hit/Byp_data look up pending writes (output register
//                 first, then the newest matching FIFO entry).
//     undefined : Byp_hit=0 and Byp_data=0; no comparators are built.
//
//   Lu handshake (valid/ready): a transfer happens at a rising Clk edge when
//   Lu_valid and Lu_ready are both high. Lu_ready depends only on the FIFO
//   occupancy (and is low during Reset), never on Lu_valid. The producer must
//   hold Lu_reg/Lu_data stable while Lu_valid is high and Lu_ready is low.
//   A transfer to register 0 is accepted and dropped.
module reg_wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int DW           = 32
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       Wb_valid,
   input  logic [4:0]                 Wb_reg,
   input  logic [DW-1:0]              Wb_data,
   input  logic                       Lu_valid,
   output logic                       Lu_ready,
   input  logic [4:0]                 Lu_reg,
   input  logic [DW-1:0]              Lu_data,
   output logic                       Stall_pipe,
   output logic                       Reg_write,
   output logic [4:0]                 Write_reg,
   output logic [DW-1:0]              Write_data,
   input  logic [4:0]                 Byp_reg,
   output logic                       Byp_hit,
   output logic [DW-1:0]              Byp_data,
   output logic [$clog2(DEPTH+1)-1:0] Count,
   output logic                       Dbg_state   // 0 = NORMAL, 1 = DRAIN
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   // One spare count above the limit so the counter cannot wrap during the
   // cycle in which the DRAIN transition is taken.
   localparam int SW = $clog2(STARVE_LIMIT + 2);

   localparam logic [CW-1:0] FULL       = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_DRAIN  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [4:0]      fifo_reg  [DEPTH];
   logic [DW-1:0]   fifo_data [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [SW-1:0]   starve;
   logic [SW-1:0]   starve_next;

   logic            enq;
   logic            deq;
   logic            sel_we;
   logic [4:0]      sel_reg;
   logic [DW-1:0]   sel_data;

   assign Count     = count;
   assign Dbg_state = (state == ST_DRAIN);

   // Ready is a pure function of occupancy, held low while in reset.
   assign Lu_ready = (count < FULL) & ~Reset;

   // Register 0 results are consumed but never stored.
   assign enq = Lu_valid & Lu_ready & (Lu_reg != 5'd0);

   // Write-port selection: DRAIN empties the FIFO; NORMAL favours the pipeline.
   always_comb begin
      deq      = 1'b0;
      sel_we   = 1'b0;
      sel_reg  = 5'd0;
      sel_data = '0;
      if (state == ST_DRAIN) begin
         if (count != '0) begin
            deq      = 1'b1;
            sel_we   = 1'b1;
            sel_reg  = fifo_reg[rd_ptr];
            sel_data = fifo_data[rd_ptr];
         end
      end else if (Wb_valid && (Wb_reg != 5'd0)) begin
         sel_we   = 1'b1;
         sel_reg  = Wb_reg;
         sel_data = Wb_data;
      end else if (count != '0) begin
         deq      = 1'b1;
         sel_we   = 1'b1;
         sel_reg  = fifo_reg[rd_ptr];
         sel_data = fifo_data[rd_ptr];
      end
   end

   // Occupancy after this edge; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_next = count;
      if (enq && !deq) begin
         count_next = count + 1'b1;
      end else if (!enq && deq) begin
         count_next = count - 1'b1;
      end
   end

   // Head-wait counter: counts cycles a non-empty FIFO's head is passed over.
   always_comb begin
      starve_next = starve + 1'b1;
      if ((count == '0) || deq) begin
         starve_next = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_NORMAL;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state: enter DRAIN on full or starved head, leave once empty.
   always_comb begin
      state_next = state;
      case (state)
         ST_NORMAL: begin
            if ((count == FULL) || (starve == STARVE_MAX)) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (count_next == '0) begin
               state_next = ST_NORMAL;
            end
         end
         default: state_next = ST_NORMAL;
      endcase
   end

   // FSM outputs: the pipeline is frozen for the whole of DRAIN.
   always_comb begin
      Stall_pipe = 1'b0;
      if (state == ST_DRAIN) begin
         Stall_pipe = 1'b1;
      end
   end

   // FIFO pointers, occupancy and head-wait counter.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         starve <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count  <= count_next;
         starve <= starve_next;
      end
   end

   // FIFO storage; contents are qualified by count so need no reset.
   always_ff @(posedge Clk) begin
      if (enq) begin
         fifo_reg[wr_ptr]  <= Lu_reg;
         fifo_data[wr_ptr] <= Lu_data;
      end
   end

   // Output register toward the register file, reloaded every cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Reg_write  <= 1'b0;
         Write_reg  <= 5'd0;
         Write_data <= '0;
      end else begin
         Reg_write  <= sel_we;
         Write_reg  <= sel_reg;
         Write_data <= sel_data;
      end
   end

`ifdef WB_BYPASS_EN
   logic [PW-1:0] byp_idx;

   // Pending-write lookup: walk oldest to newest so the newest FIFO match
   // wins, then let the output register override everything.
   always_comb begin
      Byp_hit  = 1'b0;
      Byp_data = '0;
      byp_idx  = rd_ptr;
      if (Byp_reg != 5'd0) begin
         for (int k = 0; k < DEPTH; k++) begin
            byp_idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (fifo_reg[byp_idx] == Byp_reg)) begin
               Byp_hit  = 1'b1;
               Byp_data = fifo_data[byp_idx];
            end
         end
         if (Reg_write && (Write_reg == Byp_reg)) begin
            Byp_hit  = 1'b1;
            Byp_data = Write_data;
         end
      end
   end
`else
   logic unused_byp_reg;

   // Lookup disabled: constant outputs, query address intentionally unused.
   assign unused_byp_reg = ^Byp_reg;
   assign Byp_hit        = 1'b0;
   assign Byp_data       = '0;
`endif

   // Sanity properties on internal state.
   a_count_bound: assert property (@(posedge Clk) disable iff (Reset)
      count <= FULL);
   a_no_reg0_write: assert property (@(posedge Clk) disable iff (Reset)
      Reg_write |-> (Write_reg != 5'd0));
   a_drain_stalls: assert property (@(posedge Clk) disable iff (Reset)
      (state == ST_DRAIN) |-> Stall_pipe);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the write-port rules.
module tb_reg_wb_arbiter;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int DW           = 32;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Wb_valid;
   logic [4:0]    Wb_reg;
   logic [DW-1:0] Wb_data;
   logic          Lu_valid;
   logic          Lu_ready;
   logic [4:0]    Lu_reg;
   logic [DW-1:0] Lu_data;
   logic          Stall_pipe;
   logic          Reg_write;
   logic [4:0]    Write_reg;
   logic [DW-1:0] Write_data;
   logic [4:0]    Byp_reg;
   logic          Byp_hit;
   logic [DW-1:0] Byp_data;
   logic [2:0]    Count;
   logic          Dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: FIFO of {reg, data}, drain flag, head-wait cycles,
   // and the expected register-file write of the last edge.
   logic [DW+4:0] exp_q[$];
   bit            m_drain;
   int            m_starve;
   bit            m_rw;
   logic [4:0]    m_wr;
   logic [DW-1:0] m_wd;

   // Clock / reset block
   always #5 Clk = ~Clk;

   reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .DW(DW)) dut (
      .Clk(Clk), .Reset(Reset),
      .Wb_valid(Wb_valid), .Wb_reg(Wb_reg), .Wb_data(Wb_data),
      .Lu_valid(Lu_valid), .Lu_ready(Lu_ready), .Lu_reg(Lu_reg), .Lu_data(Lu_data),
      .Stall_pipe(Stall_pipe), .Reg_write(Reg_write), .Write_reg(Write_reg),
      .Write_data(Write_data), .Byp_reg(Byp_reg), .Byp_hit(Byp_hit),
      .Byp_data(Byp_data), .Count(Count), .Dbg_state(Dbg_state)
   );

   function automatic void model_reset();
      exp_q.delete();
      m_drain  = 0;
      m_starve = 0;
      m_rw     = 0;
      m_wr     = 0;
      m_wd     = 0;
   endfunction

   // One clock edge of the write-port rules, from pre-edge state and inputs.
   function automatic void model_step(bit wbv, logic [4:0] wbr, logic [DW-1:0] wbd,
                                      bit luv, logic [4:0] lur, logic [DW-1:0] lud);
      int            cnt0     = exp_q.size();
      bit            ready    = (cnt0 < DEPTH);
      bit            popped   = 0;
      bit            to_drain = !m_drain && (cnt0 == DEPTH || m_starve == STARVE_LIMIT);
      bit            take_wb  = !m_drain && wbv && (wbr != 0);
      logic [DW+4:0] h;
      m_rw = 0;
      m_wr = 0;
      m_wd = 0;
      if (take_wb) begin
         m_rw = 1; m_wr = wbr; m_wd = wbd;
      end else if (cnt0 > 0) begin
         h = exp_q.pop_front();
         popped = 1;
         m_rw = 1; m_wr = h[DW+4:DW]; m_wd = h[DW-1:0];
      end
      m_starve = (cnt0 == 0 || popped) ? 0 : m_starve + 1;
      if (luv && ready && lur != 0) exp_q.push_back({lur, lud});
      if (m_drain) m_drain = (exp_q.size() != 0);
      else         m_drain = to_drain;
   endfunction

   function automatic bit model_byp_hit(logic [4:0] b);
      if (b == 0) return 0;
      if (m_rw && m_wr == b) return 1;
      foreach (exp_q[i]) if (exp_q[i][DW+4:DW] == b) return 1;
      return 0;
   endfunction

   function automatic logic [DW-1:0] model_byp_data(logic [4:0] b);
      if (b == 0) return '0;
      if (m_rw && m_wr == b) return m_wd;
      for (int i = exp_q.size() - 1; i >= 0; i--)
         if (exp_q[i][DW+4:DW] == b) return exp_q[i][DW-1:0];
      return '0;
   endfunction

   // Driver: apply inputs on the falling edge, advance the model, sample #1
   // after the rising edge.
   task automatic drive(input bit wbv, input logic [4:0] wbr, input logic [DW-1:0] wbd,
                        input bit luv, input logic [4:0] lur, input logic [DW-1:0] lud,
                        input logic [4:0] byp);
      @(negedge Clk);
      Wb_valid = wbv; Wb_reg = wbr; Wb_data = wbd;
      Lu_valid = luv; Lu_reg = lur; Lu_data = lud;
      Byp_reg  = byp;
      model_step(wbv, wbr, wbd, luv, lur, lud);
      @(posedge Clk);
      #1;
   endtask

   // Idle until the model reports an empty FIFO in NORMAL (bounded).
   task automatic settle();
      for (int i = 0; i < 40 && (exp_q.size() != 0 || m_drain); i++)
         drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      Reset = 1;
      Wb_valid = 0; Wb_reg = 0; Wb_data = 0;
      Lu_valid = 0; Lu_reg = 0; Lu_data = 0; Byp_reg = 0;
      #12;
      n_tests++; if (Reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b want 0", Reg_write); end
      n_tests++; if (Write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg: got %0d want 0", Write_reg); end
      n_tests++; if (Write_data !== '0) begin n_fail++; $display("FAIL reset_write_data: got %h want 0", Write_data); end
      n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", Count); end
      n_tests++; if (Stall_pipe !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall_pipe); end
      n_tests++; if (Lu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lu_ready: got %b want 0", Lu_ready); end
      n_tests++; if (Byp_hit !== 1'b0 || Byp_data !== '0) begin n_fail++; $display("FAIL reset_byp: got %b/%h want 0/0", Byp_hit, Byp_data); end
      model_reset();
      @(negedge Clk);
      Reset = 0;
      #1;
      n_tests++; if (Lu_ready !== 1'b1) begin n_fail++; $display("FAIL release_lu_ready: got %b want 1", Lu_ready); end
   endtask

   task automatic test_wb_single();
      drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
      n_tests++; if (Reg_write !== 1'b1 || Write_reg !== 5'd5 || Write_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL wb_single: got we=%b reg=%0d data=%h want 1/5/deadbeef", Reg_write, Write_reg, Write_data); end
      drive(0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (Reg_write !== 1'b0) begin n_fail++; $display("FAIL wb_single_idle: got we=%b want 0", Reg_write); end
   endtask

   task automatic test_reg_zero();
      drive(1, 5'd0, 32'h1234, 0, 0, 0, 0);
      n_tests++; if (Reg_write !== 1'b0) begin n_fail++; $display("FAIL wb_reg0: got we=%b want 0", Reg_write); end
      drive(0, 0, 0, 1, 5'd0, 32'h55, 0);
      n_tests++; if (Count !== 3'd0) begin n_fail++; $display("FAIL lu_reg0_count: got %0d want 0", Count); end
      n_tests++; if (Lu_ready !== 1'b1) begin n_fail++; $display("FAIL lu_reg0_ready: got %b want 1", Lu_ready); end
      drive(0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (Reg_write !== 1'b0) begin n_fail++; $display("FAIL lu_reg0_write: got we=%b want 0", Reg_write); end
   endtask

   task automatic fill_fifo();
      for (int i = 0; i < 4; i++)
         drive(1, 5'(20 + i), 32'(100 + i), 1, 5'(8 + i), 32'(i + 1), 0);
   endtask

   task automatic test_fifo_full_drain();
      fill_fifo();
      n_tests++; if (Count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", Count); end
      n_tests++; if (Lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", Lu_ready); end
      n_tests++; if (Stall_pipe !== 1'b0) begin n_fail++; $display("FAIL full_stall_early: got %b want 0", Stall_pipe); end
      drive(1, 5'd25, 32'h200, 0, 0, 0, 0);
      n_tests++; if (Stall_pipe !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b want 1", Stall_pipe); end
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'd26, 32'h300, 0, 0, 0, 0);
         n_tests++; if (Reg_write !== 1'b1 || Write_reg !== 5'(8 + i) || Write_data !== 32'(i + 1)) begin
            n_fail++; $display("FAIL drain_order[%0d]: got we=%b reg=%0d data=%h want 1/%0d/%0d", i, Reg_write, Write_reg, Write_data, 8 + i, i + 1); end
      end
      n_tests++; if (Stall_pipe !== 1'b0 || Count !== 3'd0) begin n_fail++; $display("FAIL drain_done: got stall=%b count=%0d want 0/0", Stall_pipe, Count); end
   endtask

   task automatic test_starve();
      int            found = -1;
      logic [DW-1:0] got_data = '0;
      bit            st[31];
      drive(1, 5'd3, 32'h100, 1, 5'd7, 32'hA5, 0);
      for (int c = 1; c <= 30; c++) begin
         drive(1, 5'd3, 32'(256 + c), 0, 0, 0, 0);
         st[c] = Stall_pipe;
         if (found < 0 && Reg_write && Write_reg == 5'd7) begin found = c; got_data = Write_data; end
      end
      n_tests++; if (found != 10) begin n_fail++; $display("FAIL starve_cycle: got %0d want 10", found); end
      n_tests++; if (got_data !== 32'hA5) begin n_fail++; $display("FAIL starve_data: got %h want a5", got_data); end
      n_tests++; if (st[8] !== 1'b0 || st[9] !== 1'b1 || st[10] !== 1'b0) begin
         n_fail++; $display("FAIL starve_stall: got %b%b%b want 010", st[8], st[9], st[10]); end
      settle();
   endtask

   task automatic test_bypass();
      bit            eh;
      logic [DW-1:0] ed;
      drive(1, 5'd3, 32'h10, 1, 5'd12, 32'h77, 5'd12);
      eh = 0; ed = '0;
`ifdef WB_BYPASS_EN
      eh = 1; ed = 32'h77;
`endif
      n_tests++; if (Byp_hit !== eh || Byp_data !== ed) begin n_fail++; $display("FAIL byp_fifo: got %b/%h want %b/%h", Byp_hit, Byp_data, eh, ed); end
      drive(1, 5'd3, 32'h11, 0, 0, 0, 5'd0);
      n_tests++; if (Byp_hit !== 1'b0 || Byp_data !== '0) begin n_fail++; $display("FAIL byp_reg0: got %b/%h want 0/0", Byp_hit, Byp_data); end
      settle();
   endtask

   task automatic test_random();
      bit            wbv, luv, eh;
      logic [4:0]    wbr, lur, byp;
      logic [DW-1:0] ed;
      for (int c = 0; c < 400; c++) begin
         wbv = ($urandom_range(0, 3) != 0);
         wbr = 5'($urandom_range(0, 7));
         luv = ($urandom_range(0, 1) != 0);
         lur = 5'($urandom_range(0, 7));
         byp = 5'($urandom_range(0, 7));
         drive(wbv, wbr, $urandom, luv, lur, $urandom, byp);
         eh = 0; ed = '0;
`ifdef WB_BYPASS_EN
         eh = model_byp_hit(byp); ed = model_byp_data(byp);
`endif
         n_tests++; if (Reg_write !== m_rw) begin n_fail++; $display("FAIL rnd_we @%0d: got %b want %b", c, Reg_write, m_rw); end
         if (m_rw) begin
            n_tests++; if (Write_reg !== m_wr || Write_data !== m_wd) begin
               n_fail++; $display("FAIL rnd_write @%0d: got %0d/%h want %0d/%h", c, Write_reg, Write_data, m_wr, m_wd); end
         end
         n_tests++; if (Count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, Count, exp_q.size()); end
         n_tests++; if (Lu_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", c, Lu_ready, exp_q.size() < DEPTH); end
         n_tests++; if (Stall_pipe !== m_drain || Dbg_state !== m_drain) begin
            n_fail++; $display("FAIL rnd_stall @%0d: got %b/%b want %b", c, Stall_pipe, Dbg_state, m_drain); end
         n_tests++; if (Byp_hit !== eh || Byp_data !== ed) begin
            n_fail++; $display("FAIL rnd_byp @%0d: got %b/%h want %b/%h", c, Byp_hit, Byp_data, eh, ed); end
      end
      settle();
   endtask

   task automatic test_reset_mid_drain();
      fill_fifo();
      drive(1, 5'd25, 32'h1, 0, 0, 0, 0);
      drive(1, 5'd25, 32'h2, 0, 0, 0, 0);
      n_tests++; if (Count !== 3'd3 || Stall_pipe !== 1'b1) begin
         n_fail++; $display("FAIL mid_drain_pre: got count=%0d stall=%b want 3/1", Count, Stall_pipe); end
      #2;
      Reset = 1;
      #1;
      n_tests++; if (Count !== 3'd0 || Stall_pipe !== 1'b0 || Reg_write !== 1'b0) begin
         n_fail++; $display("FAIL mid_drain_reset: got count=%0d stall=%b we=%b want 0/0/0", Count, Stall_pipe, Reg_write); end
      n_tests++; if (Lu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_drain_ready_rst: got %b want 0", Lu_ready); end
      model_reset();
      @(negedge Clk);
      Reset = 0;
      #1;
      n_tests++; if (Lu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_drain_ready_rel: got %b want 1", Lu_ready); end
      drive(0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (Reg_write !== 1'b0 || Count !== 3'd0) begin
         n_fail++; $display("FAIL mid_drain_after: got we=%b count=%0d want 0/0", Reg_write, Count); end
   endtask

   initial begin
      test_reset();
      test_wb_single();
      test_reg_zero();
      test_fifo_full_drain();
      test_starve();
      test_bypass();
      test_random();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
